// File: rtl/count_sched.sv
// count_sched: round-robin scheduler granting a shared counter run of latched length to one requester.
// Optional COUNT_SCHED_PAUSE_EN adds a pause input that freezes a run in progress.
module count_sched #(
    parameter int N         = 6,
    parameter int NREQ      = 4,
    parameter int MAX_COUNT = 54
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] len,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [N-1:0]      cnt
`ifdef COUNT_SCHED_PAUSE_EN
    ,
    input  logic              pause
`endif
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam logic [N:0] LTOP = (N+1)'(MAX_COUNT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [IW-1:0] last, win;
    logic [N-1:0]  lim, lim_n, sel;
    logic          found, adv;

`ifdef COUNT_SCHED_PAUSE_EN
    assign adv = !pause;
`else
    assign adv = 1'b1;
`endif

    // Search starts one past the last grantee so every requester gets its turn.
    always_comb begin
        int j;
        j     = 0;
        win   = last;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last) + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = IW'(j);
                sel   = len[j*N +: N];
            end
        end
    end

    // Stored as L-1: the terminal count value of the run.
    assign lim_n = sel == '0 ? '0 : {1'b0, sel} > LTOP ? N'(MAX_COUNT) : sel - N'(1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = |req ? RUN : IDLE;
            RUN:     state_n = adv && cnt == lim ? DONE : RUN;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign done = state == DONE ? gnt : '0;
    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            cnt   <= '0;
            lim   <= '0;
            last  <= IW'(NREQ - 1);
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (|req) begin
                    gnt  <= NREQ'(1) << win;
                    last <= win;
                    lim  <= lim_n;
                end
                RUN: if (adv && cnt != lim) cnt <= cnt + N'(1);
                DONE: begin
                    gnt <= '0;
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 Parameter: N, 6, counter width in bits.
REQ-002 Parameter: NREQ, 4, number of requesters.
REQ-003 Parameter: MAX_COUNT, 54, highest count value ever driven on cnt.
REQ-004 Port: clk  in  1  clock; all state changes on rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: req  in  NREQ  per-requester run request, level-sensitive.
REQ-007 Port: len  in  NREQ*N  packed run lengths; requester i at bits [i*N +: N].
REQ-008 Port: gnt  out  NREQ  one-hot grant; held for the whole run.
REQ-009 Port: done  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 Port: busy  out  1  high in RUN and DONE states.
REQ-011 Port: cnt  out  N  shared count value.

Function
REQ-012 FSM states: IDLE, RUN, DONE; transitions only IDLE->RUN, RUN->DONE, DONE->IDLE, RUN->RUN.
REQ-013 IDLE with req != 0: select winner by round-robin starting at (last grantee + 1) mod NREQ; latch its len; next edge enter RUN with gnt one-hot on winner and cnt = 0.
REQ-014 IDLE with req == 0: remain IDLE; gnt = 0, cnt = 0.
REQ-015 Grant latency: req sampled high at edge t gives gnt high from edge t+1.
REQ-016 Effective length L = 1 if latched len = 0, MAX_COUNT+1 if latched len > MAX_COUNT+1, else latched len.
REQ-017 RUN: cnt increments by 1 per cycle, taking values 0..L-1; when cnt = L-1, next edge enters DONE.
REQ-018 cnt never exceeds MAX_COUNT; no wrap-around occurs inside a run.
REQ-019 DONE: lasts exactly one cycle; done = gnt; gnt still asserted; cnt holds L-1; next edge enters IDLE with gnt = 0 and cnt = 0.
REQ-020 Minimum gap between runs: one IDLE cycle; back-to-back grants cannot occur without it.
REQ-021 Changes on req or len during RUN/DONE are ignored; a run always completes once granted.
REQ-022 Last-grantee pointer updates on the IDLE->RUN edge to the new winner.
REQ-023 gnt and done are always zero or one-hot; done is never high outside DONE.

Reset
REQ-024 On rst: state = IDLE; gnt = 0, done = 0, busy = 0, cnt = 0; last-grantee pointer = NREQ-1, so requester 0 has first priority.
REQ-025 rst asserted mid-run aborts the run immediately with no done pulse; the first grant after release follows REQ-024 priority.

Configuration
REQ-026 Macro COUNT_SCHED_PAUSE_EN defined: adds input port pause (1 bit); while pause is high in RUN, cnt and state hold; pause has no effect in IDLE or DONE; gnt stays asserted while paused.
REQ-027 Macro COUNT_SCHED_PAUSE_EN undefined: no pause port; RUN always advances every cycle.

Verification
REQ-028 Single request: req = 0001, len0 = 3 at edge t -> gnt = 0001 from t+1; cnt 0,1,2 at t+1..t+3; done = 0001 at t+4; gnt = 0 and busy = 0 at t+5.
REQ-029 Round-robin: req = 1111 held, all len = 2 -> grants in order 0001, 0010, 0100, 1000, 0001, each run 4 cycles incl. IDLE gap.
REQ-030 Boundary lengths: len = 0 -> one RUN cycle with cnt = 0; len = 63 -> cnt reaches 54 then DONE, never 55.
REQ-031 Reset mid-run: requester 2 granted, len = 20, assert rst at cnt = 7 -> all outputs 0 immediately, no done; after release with req = 0101, requester 0 granted first.
REQ-032 Pause (COUNT_SCHED_PAUSE_EN): len = 5, pause high 3 cycles at cnt = 2 -> cnt holds 2 for 3 cycles; done arrives 3 cycles later than REQ-028 timing.
